// File: rtl/delta_dram_pkg.sv
// Shared types and constants for the DRAM responder memory model.
package delta_dram_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 16;

   localparam logic [DATA_W-1:0] OOB_READ_VALUE = 32'h0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2,
      HOLD = 2'd3
   } state_e;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_e;

   // Saturating increment for the completion counters.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/delta_dram_mem.sv
// Word array with a front-end port and a backdoor port; front-end write wins on a same-word collision.
module delta_dram_mem
   import delta_dram_pkg::*;
#(
   parameter int unsigned DEPTH = 65536,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              fe_we,
   input  logic [AW-1:0]     fe_waddr,
   input  logic [DATA_W-1:0] fe_wdata,
   input  logic [AW-1:0]     fe_raddr,
   output logic [DATA_W-1:0] fe_rdata_c,
   input  logic              bd_we,
   input  logic [AW-1:0]     bd_addr,
   input  logic [DATA_W-1:0] bd_wdata,
   output logic [DATA_W-1:0] bd_rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] bd_rdata_q;
   logic              bd_blocked_c;

   // Backdoor write is suppressed when the front end writes the same word this cycle.
   assign bd_blocked_c = fe_we && (fe_waddr == bd_addr);

   // Array writes; contents are intentionally not reset.
   always_ff @(posedge clock) begin
      if (bd_we && !bd_blocked_c) begin
         mem_q[bd_addr] <= bd_wdata;
      end
      if (fe_we) begin
         mem_q[fe_waddr] <= fe_wdata;
      end
   end

   // Front-end read is combinational so the FSM can register it on entry to RESP.
   assign fe_rdata_c = mem_q[fe_raddr];

   // Backdoor read, one-cycle registered.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bd_rdata_q <= '0;
      end else begin
         bd_rdata_q <= mem_q[bd_addr];
      end
   end

   assign bd_rdata = bd_rdata_q;

endmodule

// File: rtl/delta_dram_responder.sv
// DRAM port responder: serves level-held read/write requests with fixed latency, stalls and error tracking.
module delta_dram_responder
   import delta_dram_pkg::*;
#(
   parameter int unsigned DEPTH   = 65536,
   parameter int unsigned LATENCY = 4,
   parameter int unsigned GAP     = 1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     DRAM_Read,
   input  logic                     DRAM_Write,
   input  logic [31:0]              DRAM_Address,
   input  logic [31:0]              DRAM_WriteData,
   output logic [31:0]              DRAM_ReadData,
   output logic                     DRAM_DataReady,
   output logic                     DRAM_WriteDone,
   input  logic                     stall,
   input  logic                     bd_we,
   input  logic [$clog2(DEPTH)-1:0] bd_addr,
   input  logic [31:0]              bd_wdata,
   output logic [31:0]              bd_rdata,
   output logic                     err_conflict,
   output logic                     err_oob,
   output logic                     err_misalign,
   output logic [15:0]              rd_count,
   output logic [15:0]              wr_count
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned MAX_C = (LATENCY > GAP) ? LATENCY : GAP;
   localparam int unsigned CW    = $clog2(MAX_C + 1);

   state_e            state_q, state_d;
   op_e               op_q, op_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [AW-1:0]     idx_q, idx_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              oob_q, oob_d;
   logic [DATA_W-1:0] read_data_q, read_data_d;
   logic              data_ready_q, data_ready_d;
   logic              write_done_q, write_done_d;
   logic              err_conflict_q, err_conflict_d;
   logic              err_oob_q, err_oob_d;
   logic              err_misalign_q, err_misalign_d;
   logic [CNT_W-1:0]  rd_count_q, rd_count_d;
   logic [CNT_W-1:0]  wr_count_q, wr_count_d;

   logic [AW-1:0]     req_idx_c;
   logic              req_oob_c;
   logic              req_line_c;
   logic              enter_resp_c;
   logic [AW-1:0]     rd_idx_c;
   logic [DATA_W-1:0] mem_rdata_c;
   logic              fe_we_c;

   // Decode of the incoming byte address.
   assign req_idx_c  = DRAM_Address[AW+1:2];
   assign req_oob_c  = |(DRAM_Address >> (AW + 2));
   assign req_line_c = (op_q == OP_WR) ? DRAM_Write : DRAM_Read;

   // In IDLE the read port looks at the live address so a one-cycle latency still gets data.
   assign rd_idx_c = (state_q == IDLE) ? req_idx_c : idx_q;

   // Commit the captured write during RESP unless the address was out of range.
   assign fe_we_c = (state_q == RESP) && (op_q == OP_WR) && !oob_q;

   delta_dram_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clock      (clock),
      .reset      (reset),
      .fe_we      (fe_we_c),
      .fe_waddr   (idx_q),
      .fe_wdata   (wdata_q),
      .fe_raddr   (rd_idx_c),
      .fe_rdata_c (mem_rdata_c),
      .bd_we      (bd_we),
      .bd_addr    (bd_addr),
      .bd_wdata   (bd_wdata),
      .bd_rdata   (bd_rdata)
   );

   // Next-state, capture, completion and bookkeeping logic.
   always_comb begin
      state_d        = state_q;
      op_d           = op_q;
      cnt_d          = cnt_q;
      idx_d          = idx_q;
      wdata_d        = wdata_q;
      oob_d          = oob_q;
      read_data_d    = '0;
      data_ready_d   = 1'b0;
      write_done_d   = 1'b0;
      err_conflict_d = err_conflict_q;
      err_oob_d      = err_oob_q;
      err_misalign_d = err_misalign_q;
      rd_count_d     = rd_count_q;
      wr_count_d     = wr_count_q;
      enter_resp_c   = 1'b0;

      case (state_q)
         IDLE: begin
            if (DRAM_Write || DRAM_Read) begin
               op_d           = DRAM_Write ? OP_WR : OP_RD;
               idx_d          = req_idx_c;
               wdata_d        = DRAM_WriteData;
               oob_d          = req_oob_c;
               err_conflict_d = err_conflict_q | (DRAM_Write & DRAM_Read);
               err_oob_d      = err_oob_q | req_oob_c;
               err_misalign_d = err_misalign_q | (|DRAM_Address[1:0]);
               cnt_d          = CW'(LATENCY - 1);
               if (LATENCY <= 1) begin
                  state_d      = RESP;
                  enter_resp_c = 1'b1;
               end else begin
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            if (!req_line_c) begin
               state_d = IDLE;
            end else if (!stall) begin
               if (cnt_q <= CW'(1)) begin
                  state_d      = RESP;
                  enter_resp_c = 1'b1;
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
         end
         RESP: begin
            state_d = HOLD;
            cnt_d   = CW'(GAP - 1);
         end
         HOLD: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Completion outputs are registered on the edge that enters RESP.
      if (enter_resp_c) begin
         if (op_d == OP_RD) begin
            data_ready_d = 1'b1;
            read_data_d  = oob_d ? OOB_READ_VALUE : mem_rdata_c;
            rd_count_d   = sat_inc(rd_count_q);
         end else begin
            write_done_d = 1'b1;
            wr_count_d   = sat_inc(wr_count_q);
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         op_q           <= OP_RD;
         cnt_q          <= '0;
         idx_q          <= '0;
         wdata_q        <= '0;
         oob_q          <= 1'b0;
         read_data_q    <= '0;
         data_ready_q   <= 1'b0;
         write_done_q   <= 1'b0;
         err_conflict_q <= 1'b0;
         err_oob_q      <= 1'b0;
         err_misalign_q <= 1'b0;
         rd_count_q     <= '0;
         wr_count_q     <= '0;
      end else begin
         state_q        <= state_d;
         op_q           <= op_d;
         cnt_q          <= cnt_d;
         idx_q          <= idx_d;
         wdata_q        <= wdata_d;
         oob_q          <= oob_d;
         read_data_q    <= read_data_d;
         data_ready_q   <= data_ready_d;
         write_done_q   <= write_done_d;
         err_conflict_q <= err_conflict_d;
         err_oob_q      <= err_oob_d;
         err_misalign_q <= err_misalign_d;
         rd_count_q     <= rd_count_d;
         wr_count_q     <= wr_count_d;
      end
   end

   assign DRAM_ReadData  = read_data_q;
   assign DRAM_DataReady = data_ready_q;
   assign DRAM_WriteDone = write_done_q;
   assign err_conflict   = err_conflict_q;
   assign err_oob        = err_oob_q;
   assign err_misalign   = err_misalign_q;
   assign rd_count       = rd_count_q;
   assign wr_count       = wr_count_q;

endmodule
